depuncture_wifi_param: RTL and testbench
========================================

# depuncture_wifi_param

Parametrised soft-decision depuncturer for the WiFi PHY receive chain. It sits between the deinterleaver and the Viterbi decoder. It accepts one signed soft symbol per beat and re-inserts erasures according to the 802.11 puncturing pattern for rate 1/2, 2/3, 3/4 or 5/6, selected per frame. It emits one (A,B) coded pair per beat with per-bit erasure flags, under valid/ready flow control on both sides.

## Interface
- SOFT_W, 4: soft symbol width, signed two's complement; erasure value is 0.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; clock clk.
- mode  input  2  code rate: 0=1/2, 1=2/3, 2=3/4, 3=5/6. Sampled only on the first accepted symbol of a frame.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block can accept a symbol this cycle.
- in_data  input  SOFT_W  received soft symbol.
- in_last  input  1  final symbol of the frame.
- out_valid  output  1  output pair is valid.
- out_ready  input  1  downstream accepts the pair.
- out_a, out_b  output  SOFT_W each  soft bits for encoder outputs A and B; 0 when erased.
- out_era_a, out_era_b  output  1 each  the corresponding bit was punctured or padded.
- out_last  output  1  final pair of the frame.

## Operation
- Each rate uses a period of pair types:
  - FULL: A and B both received.
  - A_ONLY: A received, B erased.
  - B_ONLY: A erased, B received.
- Patterns per mode:
  - 1/2 = [FULL]
  - 2/3 = [FULL, A_ONLY]
  - 3/4 = [FULL, A_ONLY, B_ONLY]
  - 5/6 = [FULL, A_ONLY, B_ONLY, A_ONLY, B_ONLY]
- State:
  - frame_active flag.
  - Latched mode register.
  - Pattern index p (0..4, wraps to 0 after the last entry of the latched pattern).
  - half flag with A hold register, set while waiting for B of a FULL pair.
- First accepted symbol with frame_active=0 starts the frame: latches mode, sets frame_active, p=0. The mode input is ignored for the rest of the frame.
- FULL, half=0: the accepted symbol goes into the hold register and half is set. Nothing is emitted.
- FULL, half=1: emit (hold, symbol) with no erasures, clear half, advance p.
- A_ONLY: emit (symbol, 0), era_b=1, advance p.
- B_ONLY: emit (0, symbol), era_a=1, advance p.
- Symbol accepted with in_last=1:
  - The pair it completes or creates carries out_last=1.
  - If it lands in FULL with half=0, the pair is emitted immediately as (symbol, 0) with era_b=1 (pad).
  - Afterwards p=0, half=0, frame_active=0.
- Erased fields always output value 0 with the flag set. Non-erased fields pass in_data bit-exact; there is no saturation or rescaling.

## Timing
- Reset values: out_valid=0, out_a=0, out_b=0, out_era_a=0, out_era_b=0, out_last=0. Internal state: p=0, half=0, frame_active=0.
- in_ready is combinational: in_ready = !out_valid || out_ready. It is low during the reset cycle.
- The output register loads on the clock edge that accepts the completing symbol. out_valid is high from the next cycle, giving 1-cycle latency from the final contributing symbol.
- Output fields hold stable while out_valid=1 and out_ready=0.
- out_valid clears on an edge where out_ready=1, unless a new pair loads on that same edge. Simultaneous drain and load is a valid pair with no bubble.
- A FULL first half only loads the hold register; out_valid is unaffected.
- Throughput with out_ready held high: one symbol per cycle, no bubbles. Output rate never exceeds input rate.
- Reset asserted mid-frame discards the held A and any pending output. The next accepted symbol starts a new frame with a freshly sampled mode.
- in_valid=0 cycles leave all state unchanged, including a pending half pair.

## Test plan
- Rate 1/2, mode=0, inputs 1,2,3,-4, last on -4, out_ready=1:
  - Pairs (1,2), (3,-4), no erasures, out_last on the second pair.
  - First out_valid 1 cycle after symbol 2 is accepted.
- Rate 3/4, mode=2, inputs 1..8, last on 8:
  - Pairs (1,2), (3,0 eB), (0 eA,4), (5,6), (7,0 eB), (0 eA,8 last).
- Rate 5/6, mode=3, inputs 1..6:
  - Pairs (1,2), (3,0 eB), (0 eA,4), (5,0 eB), (0 eA,6).
  - p wraps, and symbol 7 then starts a new FULL pair.
- Rate 2/3, inputs 1,2,3,4,5 with last on 5:
  - Pairs (1,2), (3,0 eB), (4,5 last).
  - With last moved to 4 instead: (4,0 eB, last) is emitted, followed by a new frame.
- Backpressure at rate 3/4: hold out_ready=0 for 3 cycles mid-stream.
  - in_ready drops and the output holds stable.
  - No symbol is lost or duplicated, and the pair sequence matches the unstalled run.
- Mode change at rate 2/3: change mode mid-frame, which is ignored. Then assert reset after an odd FULL half; the next frame at mode=0 outputs (a,b) pairs aligned from its first symbol.

Source files
------------

// File: rtl/depuncture_wifi_param.sv
// -----------------------------------------------------------------------------
// depuncture_wifi_param
//
// Soft-decision depuncturer between the WiFi deinterleaver and the Viterbi
// decoder. Consumes one signed soft symbol per beat, re-inserts erasures
// following the 802.11 puncturing pattern of the frame's code rate, and emits
// one (A,B) coded pair per beat with per-bit erasure flags.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   mode       code rate 0=1/2 1=2/3 2=3/4 3=5/6, sampled on the first
//              accepted symbol of a frame only
//   in_valid   in_data / in_last valid
//   in_ready   block can accept a symbol this cycle (combinational)
//   in_data    received soft symbol, signed, SOFT_W bits
//   in_last    final symbol of the frame
//   out_valid  output pair valid
//   out_ready  downstream accepts the pair
//   out_a/b    soft bits for encoder outputs A and B, 0 when erased
//   out_era_a/b  the corresponding bit was punctured or padded
//   out_last   final pair of the frame
// -----------------------------------------------------------------------------
module depuncture_wifi_param #(
  parameter int SOFT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [SOFT_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [SOFT_W-1:0] out_a,
  output logic signed [SOFT_W-1:0] out_b,
  output logic                     out_era_a,
  output logic                     out_era_b,
  output logic                     out_last
);

  typedef enum logic [1:0] {
    PT_FULL   = 2'd0,
    PT_A_ONLY = 2'd1,
    PT_B_ONLY = 2'd2
  } pair_type_e;

  // Pair type at pattern index p for a given rate.
  //   1/2: [FULL]
  //   2/3: [FULL, A_ONLY]
  //   3/4: [FULL, A_ONLY, B_ONLY]
  //   5/6: [FULL, A_ONLY, B_ONLY, A_ONLY, B_ONLY]
  function automatic pair_type_e pair_type(input logic [1:0] m,
                                           input logic [2:0] p);
    pair_type_e t;
    t = PT_FULL;
    if (p != 3'd0) begin
      case (m)
        2'd1:    t = PT_A_ONLY;
        2'd2:    t = (p == 3'd1) ? PT_A_ONLY : PT_B_ONLY;
        // Odd indices 1 and 3 keep A, even indices 2 and 4 keep B.
        2'd3:    t = p[0] ? PT_A_ONLY : PT_B_ONLY;
        default: t = PT_FULL;
      endcase
    end
    return t;
  endfunction

  // Last valid pattern index for a given rate (period length minus one).
  function automatic logic [2:0] last_index(input logic [1:0] m);
    logic [2:0] l;
    case (m)
      2'd0:    l = 3'd0;
      2'd1:    l = 3'd1;
      2'd2:    l = 3'd2;
      default: l = 3'd4;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] next_index(input logic [1:0] m,
                                            input logic [2:0] p);
    return (p >= last_index(m)) ? 3'd0 : p + 3'd1;
  endfunction

  // Control state
  logic                     frame_active_q, frame_active_d;
  logic [1:0]               mode_q, mode_d;
  logic [2:0]               p_q, p_d;
  logic                     half_q, half_d;

  // Held A soft bit of a FULL pair waiting for its B
  logic signed [SOFT_W-1:0] hold_q, hold_d;

  // Output register
  logic                     out_valid_q, out_valid_d;
  logic signed [SOFT_W-1:0] out_a_q, out_a_d;
  logic signed [SOFT_W-1:0] out_b_q, out_b_d;
  logic                     era_a_q, era_a_d;
  logic                     era_b_q, era_b_d;
  logic                     last_q, last_d;

  logic                     accept;
  logic [1:0]               cur_mode;
  logic [2:0]               cur_p;
  logic                     cur_half;
  pair_type_e               cur_type;

  // The output register can take a new pair whenever it is empty or being
  // drained this cycle, so a full stream runs without bubbles.
  assign in_ready = !reset && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A symbol arriving outside a frame opens one: the live mode input and a
  // zero pattern index apply to it directly.
  assign cur_mode = frame_active_q ? mode_q : mode;
  assign cur_p    = frame_active_q ? p_q : 3'd0;
  assign cur_half = frame_active_q && half_q;
  assign cur_type = pair_type(cur_mode, cur_p);

  // ---- stage: symbol acceptance -> pair assembly / output register load ----
  always_comb begin
    frame_active_d = frame_active_q;
    mode_d         = mode_q;
    p_d            = p_q;
    half_d         = half_q;
    hold_d         = hold_q;

    out_valid_d    = out_valid_q && !out_ready;
    out_a_d        = out_a_q;
    out_b_d        = out_b_q;
    era_a_d        = era_a_q;
    era_b_d        = era_b_q;
    last_d         = last_q;

    if (accept) begin
      frame_active_d = !in_last;
      mode_d         = cur_mode;

      unique case (cur_type)
        PT_FULL: begin
          if (cur_half) begin
            out_valid_d = 1'b1;
            out_a_d     = hold_q;
            out_b_d     = in_data;
            era_a_d     = 1'b0;
            era_b_d     = 1'b0;
            last_d      = in_last;
            half_d      = 1'b0;
            p_d         = next_index(cur_mode, cur_p);
          end else if (in_last) begin
            // Frame ends on an A with no partner: pad B as an erasure.
            out_valid_d = 1'b1;
            out_a_d     = in_data;
            out_b_d     = '0;
            era_a_d     = 1'b0;
            era_b_d     = 1'b1;
            last_d      = 1'b1;
            half_d      = 1'b0;
            p_d         = cur_p;
          end else begin
            // First half only parks A; the output register is untouched.
            hold_d = in_data;
            half_d = 1'b1;
            p_d    = cur_p;
          end
        end
        PT_A_ONLY: begin
          out_valid_d = 1'b1;
          out_a_d     = in_data;
          out_b_d     = '0;
          era_a_d     = 1'b0;
          era_b_d     = 1'b1;
          last_d      = in_last;
          half_d      = 1'b0;
          p_d         = next_index(cur_mode, cur_p);
        end
        PT_B_ONLY: begin
          out_valid_d = 1'b1;
          out_a_d     = '0;
          out_b_d     = in_data;
          era_a_d     = 1'b1;
          era_b_d     = 1'b0;
          last_d      = in_last;
          half_d      = 1'b0;
          p_d         = next_index(cur_mode, cur_p);
        end
        default: begin
          half_d = 1'b0;
          p_d    = 3'd0;
        end
      endcase

      if (in_last) begin
        p_d    = 3'd0;
        half_d = 1'b0;
      end
    end
  end

  // ---- stage: registered state and outputs ----
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_active_q <= 1'b0;
      mode_q         <= 2'd0;
      p_q            <= 3'd0;
      half_q         <= 1'b0;
      out_valid_q    <= 1'b0;
      out_a_q        <= '0;
      out_b_q        <= '0;
      era_a_q        <= 1'b0;
      era_b_q        <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      frame_active_q <= frame_active_d;
      mode_q         <= mode_d;
      p_q            <= p_d;
      half_q         <= half_d;
      out_valid_q    <= out_valid_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      era_a_q        <= era_a_d;
      era_b_q        <= era_b_d;
      last_q         <= last_d;
    end
  end

  // The held A is only meaningful while half_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_era_a = era_a_q;
  assign out_era_b = era_b_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_depuncture_wifi_param.sv
module tb_depuncture_wifi_param;

  localparam int SOFT_W = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [1:0]               mode = 2'd0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [SOFT_W-1:0] in_data = '0;
  logic                     in_last = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [SOFT_W-1:0] out_a;
  logic signed [SOFT_W-1:0] out_b;
  logic                     out_era_a;
  logic                     out_era_b;
  logic                     out_last;

  typedef struct packed {
    logic signed [SOFT_W-1:0] a;
    logic signed [SOFT_W-1:0] b;
    logic                     ea;
    logic                     eb;
    logic                     last;
  } pair_s;

  pair_s exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: manual_ready
  logic  manual_ready = 1'b1;

  depuncture_wifi_param #(.SOFT_W(SOFT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_era_a (out_era_a),
    .out_era_b (out_era_b),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1)      out_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 2) out_ready = manual_ready;
    else                      out_ready = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference: the mother-code stream is A0 B0 A1 B1 ...; the 802.11 keep
  // masks say which of those bits were transmitted. Received symbols fill the
  // kept bits in order; unkept bits become erasures; a kept B with no symbol
  // left at frame end becomes a pad erasure.
  task automatic model_frame(input logic [1:0] m,
                             input logic signed [SOFT_W-1:0] syms[$],
                             input bit with_last);
    logic [4:0] keep_a, keep_b;
    int         period, idx, j;
    pair_s      pr;
    case (m)
      2'd0:    begin period = 1; keep_a = 5'b00001; keep_b = 5'b00001; end
      2'd1:    begin period = 2; keep_a = 5'b00011; keep_b = 5'b00001; end
      2'd2:    begin period = 3; keep_a = 5'b00011; keep_b = 5'b00101; end
      default: begin period = 5; keep_a = 5'b01011; keep_b = 5'b10101; end
    endcase
    idx = 0;
    j   = 0;
    while (idx < syms.size()) begin
      pr = '0;
      if (keep_a[j % period]) begin
        pr.a = syms[idx];
        idx++;
      end else begin
        pr.ea = 1'b1;
      end
      if (keep_b[j % period]) begin
        if (idx < syms.size()) begin
          pr.b = syms[idx];
          idx++;
        end else if (with_last) begin
          pr.eb = 1'b1;
        end else begin
          break;  // incomplete pair never leaves the block
        end
      end else begin
        pr.eb = 1'b1;
      end
      pr.last = with_last && (idx == syms.size());
      exp_q.push_back(pr);
      j++;
    end
  endtask

  // Scoreboard: every transferred pair is compared with the model's next pair.
  always @(negedge clk) begin : monitor
    pair_s g, e;
    if (!reset && out_valid && out_ready) begin
      g = {out_a, out_b, out_era_a, out_era_b, out_last};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pair_unexpected got a=%0d b=%0d ea=%0b eb=%0b last=%0b required none",
                 g.a, g.b, g.ea, g.eb, g.last);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          failures++;
          $display("FAIL pair got a=%0d b=%0d ea=%0b eb=%0b last=%0b required a=%0d b=%0d ea=%0b eb=%0b last=%0b",
                   g.a, g.b, g.ea, g.eb, g.last, e.a, e.b, e.ea, e.eb, e.last);
        end
      end
    end
  end

  task automatic send_sym(input logic signed [SOFT_W-1:0] d, input bit last,
                          input logic [1:0] m);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    mode     = m;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout got stalled=%0d required <500", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] m, input int n, input bit seq,
                            input bit with_last, input int gap_max,
                            input bit scramble);
    logic signed [SOFT_W-1:0] syms[$];
    logic [1:0]               mm;
    for (int i = 0; i < n; i++)
      syms.push_back(seq ? SOFT_W'(i + 1) : SOFT_W'($urandom_range(0, 15)));
    model_frame(m, syms, with_last);
    for (int i = 0; i < n; i++) begin
      mm = (scramble && i > 0) ? 2'($urandom_range(0, 3)) : m;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
      send_sym(syms[i], with_last && (i == n - 1), mm);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready got %0b required 0", in_ready);
    end
    checks++;
    if ({out_valid, out_a, out_b, out_era_a, out_era_b, out_last} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%0b a=%0d b=%0d ea=%0b eb=%0b l=%0b required all 0",
               out_valid, out_a, out_b, out_era_a, out_era_b, out_last);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rate12();
    logic signed [SOFT_W-1:0] q[$];
    q = '{4'sd1, 4'sd2, 4'sd3, -4'sd4};
    model_frame(2'd0, q, 1'b1);
    send_sym(q[0], 1'b0, 2'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL r12_first_half_valid got %0b required 0", out_valid);
    end
    send_sym(q[1], 1'b0, 2'd0);
    checks++;
    if (out_valid !== 1'b1 || out_a !== 4'sd1 || out_b !== 4'sd2) begin
      failures++;
      $display("FAIL r12_latency got v=%0b a=%0d b=%0d required v=1 a=1 b=2",
               out_valid, out_a, out_b);
    end
    send_sym(q[2], 1'b0, 2'd0);
    send_sym(q[3], 1'b1, 2'd0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL r12_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_rate34();
    send_frame(2'd2, 8, 1'b1, 1'b1, 0, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL r34_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_rate56_wrap();
    send_frame(2'd3, 8, 1'b1, 1'b1, 0, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL r56_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_rate23_last();
    send_frame(2'd1, 5, 1'b1, 1'b1, 0, 1'b0);
    send_frame(2'd1, 4, 1'b1, 1'b1, 0, 1'b0);
    send_frame(2'd0, 2, 1'b0, 1'b1, 0, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL r23_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    pair_s held;
    manual_ready = 1'b1;
    ready_mode   = 2;
    fork
      send_frame(2'd2, 12, 1'b1, 1'b1, 0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        manual_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (k == 0) held = {out_a, out_b, out_era_a, out_era_b, out_last};
          checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall got v=%0b in_ready=%0b required v=1 in_ready=0",
                     out_valid, in_ready);
          end
          checks++;
          if ({out_a, out_b, out_era_a, out_era_b, out_last} !== held) begin
            failures++;
            $display("FAIL bp_hold got a=%0d b=%0d required a=%0d b=%0d",
                     out_a, out_b, held.a, held.b);
          end
        end
        manual_ready = 1'b1;
      end
    join
    drain();
    ready_mode = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_mode_change_reset();
    send_frame(2'd1, 9, 1'b1, 1'b1, 1, 1'b1);
    // Odd FULL half left pending: (1,2),(3,eB) emitted, 4 parked.
    send_frame(2'd1, 4, 1'b1, 1'b0, 0, 1'b1);
    drain();
    reset = 1'b1;
    mode  = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(2'd0, 6, 1'b0, 1'b1, 0, 1'b0);
    drain();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mode_reset got pending=%0d v=%0b required 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    send_frame(2'd3, 20, 1'b0, 1'b1, 0, 1'b0);
    send_frame(2'd0, 10, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (($time - t0) != 300) begin
      failures++;
      $display("FAIL b2b_throughput got %0t required 300", $time - t0);
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    ready_mode = 1;
    for (int f = 0; f < 25; f++)
      send_frame(2'($urandom_range(0, 3)), $urandom_range(1, 24), 1'b0, 1'b1,
                 $urandom_range(0, 2), 1'b1);
    drain();
    ready_mode = 0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_missing got pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_rate12();
    test_rate34();
    test_rate56_wrap();
    test_rate23_last();
    test_backpressure();
    test_mode_change_reset();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
